// File: rtl/audio_pkg.sv
// Shared types for the audio DAC serializer: default sample width, stereo
// frame record and the serializer state encoding.
package audio_pkg;

  localparam int SAMPLE_W_DEFAULT = 16;

  typedef struct packed {
    logic [SAMPLE_W_DEFAULT-1:0] left;
    logic [SAMPLE_W_DEFAULT-1:0] right;
  } audio_frame_t;

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} dac_state_t;

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO. Read data is registered: the popped frame appears on
// rd_data_o in the cycle after pop_i is accepted.
module audio_frame_fifo
  import audio_pkg::*;
#(
  parameter type frame_t    = audio_frame_t,
  parameter int  FIFO_DEPTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        push_i,
  input  frame_t                      wr_data_i,
  input  logic                        pop_i,
  output frame_t                      rd_data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  frame_t        mem [FIFO_DEPTH];
  frame_t        rd_data_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  // Depth is a power of two, so the level MSB alone marks full.
  assign full_o    = level_q[AW];
  assign empty_o   = (level_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = rd_data_q;
  assign level_o   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= wr_data_i;
    rd_data_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer slaved to oversampled codec BCLK/DACLRCK.
// Build option AUDIO_DAC_HOLD_LAST_EN: on underrun repeat the last frame instead of silence.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W    = SAMPLE_W_DEFAULT,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk_50_clk,
  input  logic                        reset_n_reset_n,
  input  logic                        enable,
  input  logic [SAMPLE_W-1:0]         s_left,
  input  logic [SAMPLE_W-1:0]         s_right,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        audio_out_BCLK,
  input  logic                        audio_out_DACLRCK,
  output logic                        audio_out_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun
);

  localparam int CW = $clog2(SAMPLE_W);

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } word_pair_t;

  logic [SYNC_STAGES-1:0] bclk_sync_q, lrck_sync_q;
  logic                   bclk_hist_q, lrck_at_fall_q;
  logic                   bclk_s, lrck_s, bclk_fall, lrck_edge, left_bnd;

  dac_state_t             state_q;
  logic [CW-1:0]          bitcnt_q;
  logic                   chan_q, load_q, dacdat_q, underrun_q;
  logic [SAMPLE_W-1:0]    hold_l_q, hold_r_q, cur_word;

  word_pair_t             wr_frame, rd_frame;
  logic                   fifo_full, fifo_empty, fifo_pop;

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
  assign bclk_fall = bclk_hist_q & ~bclk_s;
  // LRCK is only judged at BCLK falls, matching where the codec moves it.
  assign lrck_edge = bclk_fall & (lrck_s != lrck_at_fall_q);
  assign left_bnd  = lrck_edge & ~lrck_s;
  assign fifo_pop  = left_bnd & enable & ~fifo_empty;
  assign cur_word  = chan_q ? hold_r_q : hold_l_q;
  assign wr_frame  = '{left: s_left, right: s_right};

  always_ff @(posedge clk_50_clk or negedge reset_n_reset_n) begin
    if (!reset_n_reset_n) begin
      bclk_sync_q    <= '0;
      lrck_sync_q    <= '0;
      bclk_hist_q    <= 1'b0;
      lrck_at_fall_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], audio_out_BCLK};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], audio_out_DACLRCK};
      bclk_hist_q <= bclk_s;
      if (bclk_fall) lrck_at_fall_q <= lrck_s;
    end
  end

  audio_frame_fifo #(
    .frame_t    (word_pair_t),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_50_clk),
    .rst_ni    (reset_n_reset_n),
    .push_i    (s_valid),
    .wr_data_i (wr_frame),
    .pop_i     (fifo_pop),
    .rd_data_o (rd_frame),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  always_ff @(posedge clk_50_clk or negedge reset_n_reset_n) begin
    if (!reset_n_reset_n) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      chan_q     <= 1'b0;
      load_q     <= 1'b0;
      dacdat_q   <= 1'b0;
      underrun_q <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
    end else begin
      underrun_q <= 1'b0;
      load_q     <= 1'b0;
      // FIFO read data lands one cycle after the pop, long before the next BCLK fall.
      if (load_q) begin
        hold_l_q <= rd_frame.left;
        hold_r_q <= rd_frame.right;
      end
      if (bclk_fall) begin
        if (left_bnd) begin
          dacdat_q <= 1'b0;
          chan_q   <= 1'b0;
          if (!enable) begin
            state_q <= IDLE;
          end else begin
            state_q <= DELAY;
            if (fifo_empty) begin
              underrun_q <= 1'b1;
`ifndef AUDIO_DAC_HOLD_LAST_EN
              hold_l_q <= '0;
              hold_r_q <= '0;
`endif
            end else begin
              load_q <= 1'b1;
            end
          end
        end else if (lrck_edge && state_q != IDLE) begin
          state_q  <= DELAY;
          chan_q   <= lrck_s;
          dacdat_q <= 1'b0;
        end else begin
          case (state_q)
            DELAY: begin
              dacdat_q <= cur_word[SAMPLE_W-1];
              bitcnt_q <= CW'(SAMPLE_W-1);
              state_q  <= SHIFT;
            end
            SHIFT: begin
              if (bitcnt_q == '0) begin
                dacdat_q <= 1'b0;
                state_q  <= PAD;
              end else begin
                dacdat_q <= cur_word[bitcnt_q - 1'b1];
                bitcnt_q <= bitcnt_q - 1'b1;
              end
            end
            default: dacdat_q <= 1'b0;
          endcase
        end
      end
    end
  end

  assign s_ready          = ~fifo_full;
  assign audio_out_DACDAT = dacdat_q;
  assign underrun         = underrun_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Randomized bench: a codec model drives BCLK/DACLRCK, a decoder recovers words
// on rising BCLK, and a queue-based frame model predicts every half-frame.
`timescale 1ns/1ps
module tb_audio_dac_serializer;

  localparam int SW    = 16;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          s_valid = 1'b0;
  logic [SW-1:0] s_left = '0;
  logic [SW-1:0] s_right = '0;
  logic          bclk = 1'b0;
  logic          lrck = 1'b1;
  logic          s_ready, dacdat, underrun;
  logic [LW-1:0] fifo_level;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  audio_dac_serializer #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk_50_clk        (clk),
    .reset_n_reset_n   (rst_n),
    .enable            (enable),
    .s_left            (s_left),
    .s_right           (s_right),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .audio_out_BCLK    (bclk),
    .audio_out_DACLRCK (lrck),
    .audio_out_DACDAT  (dacdat),
    .fifo_level        (fifo_level),
    .underrun          (underrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] model_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] pend_r = '0;
  logic [31:0] last_frame = '0;
  int          exp_underruns = 0;
  bit          in_reset = 1'b1;
  int          bit_idx = 0;

  // Called at every DACLRCK change; predicts the word the codec will receive in the half just begun.
  task automatic model_edge();
    logic [31:0] f;
    if (lrck == 1'b0) begin
      if (enable && !in_reset) begin
        if (model_q.size() > 0) begin
          f = model_q.pop_front();
        end else begin
          exp_underruns++;
`ifdef AUDIO_DAC_HOLD_LAST_EN
          f = last_frame;
`else
          f = '0;
`endif
        end
        last_frame = f;
        exp_q.push_back(f[31:16]);
        pend_r = f[15:0];
      end else begin
        exp_q.push_back('0);
        pend_r = '0;
      end
    end else begin
      exp_q.push_back(pend_r);
    end
  endtask

  // Codec: ~3.07 MHz BCLK, DACLRCK toggles on a BCLK fall every 32 bits.
  initial begin
    forever begin
      #163 bclk = 1'b1;
      #163 bclk = 1'b0;
      bit_idx++;
      if (bit_idx == 32) begin
        bit_idx = 0;
        lrck = ~lrck;
        model_edge();
      end
    end
  end

  // Decoder: bit 0 of each half is the I2S delay slot, bits 1..16 the word, the rest padding.
  logic        dec_prev = 1'b1;
  bit          dec_started = 1'b0;
  bit          dec_discard = 1'b0;
  int          dec_idx = 0;
  int          dec_pad_ones = 0;
  logic [15:0] dec_word = '0;

  always @(posedge bclk) begin
    if (lrck != dec_prev) begin
      if (dec_started && !dec_discard && exp_q.size() > 0) begin
        logic [15:0] w;
        w = exp_q.pop_front();
        $display("half %s: decoded %h expected %h pad_ones %0d",
                 dec_prev ? "R" : "L", dec_word, w, dec_pad_ones);
        check_eq(dec_prev ? "right_word" : "left_word", {16'h0, dec_word}, {16'h0, w});
        check_eq("pad_bits", dec_pad_ones, 0);
      end
      dec_prev     = lrck;
      dec_started  = 1'b1;
      dec_discard  = 1'b0;
      dec_idx      = 0;
      dec_word     = '0;
      dec_pad_ones = (dacdat !== 1'b0) ? 1 : 0;
    end else begin
      dec_idx++;
      if (dec_idx >= 1 && dec_idx <= 16) dec_word = {dec_word[14:0], dacdat};
      else if (dacdat !== 1'b0) dec_pad_ones++;
    end
  end

  // Underrun pulse width and count.
  int   seen_underruns = 0;
  int   ur_len = 0;
  always @(negedge clk) begin
    if (underrun === 1'b1) begin
      if (ur_len == 0) seen_underruns++;
      ur_len++;
    end else if (ur_len != 0) begin
      check_eq("underrun_width", ur_len, 1);
      ur_len = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_safe();
    int n = 0;
    while (!(bit_idx >= 2 && bit_idx <= 26) && n < 4000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic push_frame(input logic [31:0] f);
    @(negedge clk);
    s_valid = 1'b1;
    s_left  = f[31:16];
    s_right = f[15:0];
    check_eq("s_ready", {31'h0, s_ready}, (model_q.size() < DEPTH) ? 1 : 0);
    @(posedge clk);
    if (model_q.size() < DEPTH) model_q.push_back(f);
  endtask

  task automatic check_level();
    @(negedge clk);
    s_valid = 1'b0;
    $display("level: dut %0d model %0d s_ready %b", fifo_level, model_q.size(), s_ready);
    check_eq("fifo_level", {28'h0, fifo_level}, model_q.size());
    check_eq("s_ready_idle", {31'h0, s_ready}, (model_q.size() < DEPTH) ? 1 : 0);
  endtask

  task automatic after_left_boundary();
    @(negedge lrck);
    repeat (3) @(negedge bclk);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    // Reset held with BCLK running.
    repeat (10) begin
      repeat (37) @(negedge clk);
      check_eq("rst_dacdat", {31'h0, dacdat}, 0);
      check_eq("rst_s_ready", {31'h0, s_ready}, 1);
      check_eq("rst_level", {28'h0, fifo_level}, 0);
      check_eq("rst_underrun", {31'h0, underrun}, 0);
    end
    wait_safe();
    @(negedge clk);
    rst_n = 1'b1;
    in_reset = 1'b0;

    // Directed data path frame.
    wait_safe();
    push_frame(32'hA5C3_0F01);
    check_level();
    enable = 1'b1;
    repeat (2) @(negedge lrck);

    // Flow control: fill to full and try one more.
    wait_safe();
    for (int i = 0; i < DEPTH + 1; i++) push_frame($urandom);
    check_level();
    after_left_boundary();
    check_level();

    // Randomized pushes and occasional enable toggles.
    for (int it = 0; it < 30; it++) begin
      int r;
      repeat ($urandom_range(1, 40)) @(negedge bclk);
      wait_safe();
      r = $urandom_range(0, 9);
      if (r < 4) begin
        push_frame($urandom);
        check_level();
      end else if (r == 9) begin
        @(negedge clk);
        enable = ~enable;
      end
    end
    @(negedge clk);
    enable = 1'b1;

    // Disable in the middle of a right word; no pop at the next left boundary.
    wait_safe();
    push_frame($urandom);
    check_level();
    while (!(lrck == 1'b1 && bit_idx == 8)) @(negedge bclk);
    enable = 1'b0;
    after_left_boundary();
    check_level();
    @(negedge lrck);
    wait_safe();
    enable = 1'b1;
    repeat (2) @(negedge lrck);

    // Reset in the middle of a left word.
    wait_safe();
    push_frame($urandom);
    check_level();
    @(negedge lrck);
    while (!(lrck == 1'b0 && bit_idx == 8)) @(negedge bclk);
    #37;
    rst_n = 1'b0;
    in_reset = 1'b1;
    model_q.delete();
    exp_q.delete();
    pend_r = '0;
    last_frame = '0;
    dec_discard = 1'b1;
    #1;
    check_eq("midrst_dacdat", {31'h0, dacdat}, 0);
    check_eq("midrst_level", {28'h0, fifo_level}, 0);
    check_eq("midrst_s_ready", {31'h0, s_ready}, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    in_reset = 1'b0;
    wait_safe();
    push_frame($urandom);
    check_level();
    repeat (3) @(negedge lrck);

    // Drain and let the decoder finish the last halves.
    repeat (2) @(negedge lrck);
    @(posedge lrck);
    repeat (2) @(posedge bclk);
    check_eq("underrun_count", seen_underruns, exp_underruns);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
- Streaming stage directly upstream of the audio codec DAC pins (audio_out_DACDAT).
- Accepts stereo PCM frames on a valid/ready interface and buffers them in a small frame FIFO.
- Shifts samples out MSB-first in I2S format, slaved to the codec-driven BCLK/DACLRCK.
- BCLK and DACLRCK are oversampled in the 50 MHz domain; no logic is clocked by BCLK.

Parameters:
SAMPLE_W, 16, bits per channel sample
FIFO_DEPTH, 8, stereo frames buffered (power of 2, ≥2)
SYNC_STAGES, 2, flip-flops in the BCLK/DACLRCK synchronisers (≥2)

Ports:
clk_50_clk  in  1  system clock, 50 MHz
reset_n_reset_n  in  1  asynchronous active-low reset
enable  in  1  run control, sampled only at left-frame boundaries
s_left  in  SAMPLE_W  left sample, two's complement
s_right  in  SAMPLE_W  right sample, two's complement
s_valid  in  1  frame valid
s_ready  out  1  FIFO not full
audio_out_BCLK  in  1  codec bit clock
audio_out_DACLRCK  in  1  codec frame clock (0 = left, 1 = right)
audio_out_DACDAT  out  1  serial data to codec
fifo_level  out  $clog2(FIFO_DEPTH)+1  frames currently held
underrun  out  1  one-cycle pulse when a frame is needed and the FIFO is empty

Behaviour:
Reset:
- Async on reset_n_reset_n low: DACDAT=0, underrun=0, fifo_level=0, s_ready=1, FSM=IDLE, hold regs=0.
- Reset mid-word aborts the word immediately; no partial bits are emitted afterwards.

Edge detection:
- BCLK and DACLRCK each pass through a SYNC_STAGES chain, plus one history flop.
- bclk_fall = synced 1→0. lrck_edge = synced DACLRCK differs from its value at the previous bclk_fall, evaluated on bclk_fall.
- Required: BCLK period ≥ 8 clk_50_clk cycles.

FIFO:
- Push when s_valid && s_ready; s_ready = !full.
- Pop only at a left-frame boundary.
- Push and pop in the same cycle: level unchanged.
- Empty-FIFO pop request: no bypass. The concurrent push is stored, and underrun fires.

Left-frame boundary: the bclk_fall where lrck_edge is set and synced DACLRCK = 0.
- If enable=1 and FIFO is non-empty: pop into hold_l/hold_r.
- If enable=1 and FIFO is empty: underrun=1 for one cycle; hold regs loaded per the optional feature.
- If enable=0: FSM→IDLE, DACDAT=0, no pop, FIFO keeps accepting.

FSM states: IDLE, DELAY, SHIFT, PAD.
- IDLE: wait for a left-frame boundary with enable=1 → DELAY.
- DELAY: I2S one-bit slot. On the next bclk_fall, drive the MSB of the current channel (hold_l or hold_r), bitcnt=SAMPLE_W-1 → SHIFT.
- SHIFT: on each bclk_fall, drive the next bit. After the LSB is driven, → PAD with DACDAT=0.
- PAD: DACDAT=0 until lrck_edge.
- Any state except IDLE, on lrck_edge: → DELAY with the new channel selected. A short frame truncates the word.
- Right boundary (DACLRCK 1→0 is left; 0→1 is right): uses hold_r; no pop.

DACDAT timing:
- Changes only in the cycle after a detected bclk_fall; registered output.
- Codec samples on the rising BCLK.

Optional Feature:
AUDIO_DAC_HOLD_LAST_EN
- Defined: on underrun, hold_l/hold_r keep the previous frame, so the last sample repeats.
- Undefined: on underrun, hold regs are cleared to 0 (silence).
- The underrun pulse is identical in both builds.

Decomposition:
- audio_pkg holds:
  - SAMPLE_W default
  - typedef audio_frame_t {left, right}
  - typedef enum dac_state_t {IDLE, DELAY, SHIFT, PAD}
- Sub-module audio_frame_fifo: synchronous FIFO of audio_frame_t with parameter FIFO_DEPTH, exposing full/empty/level.
- Edge detection and FSM stay in the top module.

Test Plan:
- Reset: hold reset_n low with BCLK toggling → DACDAT=0, s_ready=1, fifo_level=0, underrun=0 throughout.
- Data path: push L=16'hA5C3, R=16'h0F01; BCLK 3.072 MHz, 32 BCLK per channel. A bench decoder on BCLK rising, with one-bit delay, recovers A5C3 then 0F01; bits 17–32 of each half are 0.
- Flow control: push 8 frames back-to-back → s_ready low after the 8th and the 9th is not accepted, level=8. After the next left boundary: level=7, s_ready=1.
- Underrun: empty FIFO at a left boundary → underrun high exactly 1 cycle. Frame is zeros, or a repeat of the last frame with AUDIO_DAC_HOLD_LAST_EN.
- Reset mid-word: assert reset at bit 7 of the left word → DACDAT=0 within the same cycle and level=0. After release plus one push, output restarts at the next left boundary.
- Enable: deassert enable mid-right-word → right word completes. At the next left boundary there is no pop (level unchanged), DACDAT=0 until enable=1 and a subsequent left boundary.
